// File: rtl/dcache_data_ctrl_if.sv
// Bundle between the D-cache data-array controller, its three requesters and the data SRAM.
// The slave modport is the controller's view; the master modport is the surroundings' view.
interface dcache_data_ctrl_if #(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64
);
    localparam int WORDS     = WIDTH / WORD_SIZE;
    localparam int LOG_WORDS = $clog2(WORDS);

    logic                    init_done;
    logic                    core_req_valid;
    logic                    core_req_ready;
    logic                    core_req_write;
    logic [LOG_NUM_ROWS-1:0] core_req_row;
    logic [LOG_WORDS-1:0]    core_req_word;
    logic [WORD_SIZE-1:0]    core_req_wdata;
    logic                    core_resp_valid;
    logic [WORD_SIZE-1:0]    core_resp_data;
    logic                    fill_valid;
    logic                    fill_ready;
    logic [LOG_NUM_ROWS-1:0] fill_row;
    logic [WIDTH-1:0]        fill_data;
    logic                    evict_req_valid;
    logic                    evict_req_ready;
    logic [LOG_NUM_ROWS-1:0] evict_row;
    logic                    evict_resp_valid;
    logic [WIDTH-1:0]        evict_resp_data;
    logic [LOG_NUM_ROWS-1:0] sram_read_addr;
    logic [WIDTH-1:0]        sram_read_data;
    logic [LOG_NUM_ROWS-1:0] sram_write_addr;
    logic [WIDTH-1:0]        sram_write_data;
    logic [WORDS-1:0]        sram_write_enable;

    modport slave (
        output init_done, core_req_ready, core_resp_valid, core_resp_data,
               fill_ready, evict_req_ready, evict_resp_valid, evict_resp_data,
               sram_read_addr, sram_write_addr, sram_write_data, sram_write_enable,
        input  core_req_valid, core_req_write, core_req_row, core_req_word, core_req_wdata,
               fill_valid, fill_row, fill_data, evict_req_valid, evict_row, sram_read_data
    );

    modport master (
        input  init_done, core_req_ready, core_resp_valid, core_resp_data,
               fill_ready, evict_req_ready, evict_resp_valid, evict_resp_data,
               sram_read_addr, sram_write_addr, sram_write_data, sram_write_enable,
        output core_req_valid, core_req_write, core_req_row, core_req_word, core_req_wdata,
               fill_valid, fill_row, fill_data, evict_req_valid, evict_row, sram_read_data
    );
endinterface

// File: rtl/dcache_data_ctrl.sv
// L1 D-cache data-array controller: zero-fills the array after reset, then arbitrates the single
// SRAM read and write ports among core, refill and writeback, forwarding same-row writes into reads.
module dcache_data_ctrl #(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    dcache_data_ctrl_if.slave bus
);
    localparam int NUM_ROWS  = 2 ** LOG_NUM_ROWS;
    localparam int WORDS     = WIDTH / WORD_SIZE;
    localparam int LOG_WORDS = $clog2(WORDS);
    localparam int WAIT_W    = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [LOG_NUM_ROWS-1:0] init_cnt_r, init_cnt_s;
    logic [WAIT_W-1:0]       wait_cnt_r, wait_cnt_s;
    logic                    core_pend_r, core_pend_s;
    logic                    evict_pend_r, evict_pend_s;
    logic [LOG_WORDS-1:0]    resp_word_r, resp_word_s;
    logic [WORDS-1:0]        fwd_mask_r, fwd_mask_s;
    logic [WIDTH-1:0]        fwd_data_r, fwd_data_s;

    logic                    run_s;
    logic                    starve_s;
    logic                    core_rd_s;
    logic                    core_wr_s;
    logic                    fill_go_s;
    logic                    evict_go_s;
    logic                    core_rd_go_s;
    logic                    core_wr_go_s;
    logic [WIDTH-1:0]        merged_s;

    function automatic logic [WORDS-1:0] word_enable(input logic [LOG_WORDS-1:0] idx);
        logic [WORDS-1:0] en;
        en      = '0;
        en[idx] = 1'b1;
        return en;
    endfunction

    function automatic logic [WIDTH-1:0] word_to_line(input logic [WORD_SIZE-1:0] w,
                                                      input logic [LOG_WORDS-1:0] idx);
        logic [WIDTH-1:0] line;
        line = '0;
        for (int i = 0; i < WORDS; i++) begin
            line[i*WORD_SIZE +: WORD_SIZE] = (LOG_WORDS'(i) == idx) ? w : '0;
        end
        return line;
    endfunction

    // Words written in the issuing cycle override the stale data the SRAM returns.
    function automatic logic [WIDTH-1:0] merge_line(input logic [WIDTH-1:0] raw,
                                                    input logic [WORDS-1:0] mask,
                                                    input logic [WIDTH-1:0] fwd);
        logic [WIDTH-1:0] line;
        line = raw;
        for (int i = 0; i < WORDS; i++) begin
            line[i*WORD_SIZE +: WORD_SIZE] = mask[i] ? fwd[i*WORD_SIZE +: WORD_SIZE]
                                                     : raw[i*WORD_SIZE +: WORD_SIZE];
        end
        return line;
    endfunction

    // Port arbitration: fill owns the write port and evict the read port unless the core is starved.
    always_comb begin
        run_s        = (state_r == RUN);
        starve_s     = (wait_cnt_r == WAIT_W'(STARVE_LIMIT));
        core_rd_s    = bus.core_req_valid && !bus.core_req_write;
        core_wr_s    = bus.core_req_valid && bus.core_req_write;
        bus.core_req_ready  = run_s && bus.core_req_valid &&
                              (bus.core_req_write ? (!bus.fill_valid || starve_s)
                                                  : (!bus.evict_req_valid || starve_s));
        bus.fill_ready      = run_s && bus.fill_valid && !(starve_s && core_wr_s);
        bus.evict_req_ready = run_s && bus.evict_req_valid && !(starve_s && core_rd_s);
        fill_go_s    = bus.fill_valid && bus.fill_ready;
        evict_go_s   = bus.evict_req_valid && bus.evict_req_ready;
        core_rd_go_s = core_rd_s && bus.core_req_ready;
        core_wr_go_s = core_wr_s && bus.core_req_ready;
    end

    // SRAM write port: zero-fill during INIT, otherwise the granted writer or idle zeros.
    always_comb begin
        bus.sram_write_addr   = '0;
        bus.sram_write_data   = '0;
        bus.sram_write_enable = '0;
        if (!run_s) begin
            bus.sram_write_addr   = init_cnt_r;
            bus.sram_write_data   = '0;
            bus.sram_write_enable = '1;
        end else if (fill_go_s) begin
            bus.sram_write_addr   = bus.fill_row;
            bus.sram_write_data   = bus.fill_data;
            bus.sram_write_enable = '1;
        end else if (core_wr_go_s) begin
            bus.sram_write_addr   = bus.core_req_row;
            bus.sram_write_data   = word_to_line(bus.core_req_wdata, bus.core_req_word);
            bus.sram_write_enable = word_enable(bus.core_req_word);
        end else begin
            bus.sram_write_addr   = '0;
            bus.sram_write_data   = '0;
            bus.sram_write_enable = '0;
        end
    end

    // SRAM read port plus the bookkeeping that travels with the read to its response cycle.
    always_comb begin
        bus.sram_read_addr = '0;
        core_pend_s        = core_rd_go_s;
        evict_pend_s       = evict_go_s;
        resp_word_s        = resp_word_r;
        fwd_mask_s         = '0;
        fwd_data_s         = '0;
        if (evict_go_s) begin
            bus.sram_read_addr = bus.evict_row;
        end else if (core_rd_go_s) begin
            bus.sram_read_addr = bus.core_req_row;
            resp_word_s        = bus.core_req_word;
        end else begin
            bus.sram_read_addr = '0;
        end
        if ((evict_go_s || core_rd_go_s) && (bus.sram_write_enable != '0) && run_s &&
            (bus.sram_read_addr == bus.sram_write_addr)) begin
            fwd_mask_s = bus.sram_write_enable;
            fwd_data_s = bus.sram_write_data;
        end else begin
            fwd_mask_s = '0;
            fwd_data_s = '0;
        end
    end

    // Next-state logic for the INIT/RUN sequencer and the core starvation counter.
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            INIT: begin
                init_cnt_s = init_cnt_r + LOG_NUM_ROWS'(1);
                if (init_cnt_r == LOG_NUM_ROWS'(NUM_ROWS - 1)) begin
                    state_s = RUN;
                end else begin
                    state_s = INIT;
                end
            end
            RUN: begin
                state_s = RUN;
                if (core_rd_go_s || core_wr_go_s) begin
                    wait_cnt_s = '0;
                end else if (bus.core_req_valid && !starve_s) begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end else begin
                    wait_cnt_s = wait_cnt_r;
                end
            end
            default: begin
                state_s    = INIT;
                init_cnt_s = '0;
                wait_cnt_s = '0;
            end
        endcase
    end

    // State and response-pipeline registers; reset drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= INIT;
            init_cnt_r   <= '0;
            wait_cnt_r   <= '0;
            core_pend_r  <= 1'b0;
            evict_pend_r <= 1'b0;
            resp_word_r  <= '0;
            fwd_mask_r   <= '0;
            fwd_data_r   <= '0;
        end else begin
            state_r      <= state_s;
            init_cnt_r   <= init_cnt_s;
            wait_cnt_r   <= wait_cnt_s;
            core_pend_r  <= core_pend_s;
            evict_pend_r <= evict_pend_s;
            resp_word_r  <= resp_word_s;
            fwd_mask_r   <= fwd_mask_s;
            fwd_data_r   <= fwd_data_s;
        end
    end

    // Response outputs come straight off the pending flags; data is zero when no response is due.
    always_comb begin
        merged_s             = merge_line(bus.sram_read_data, fwd_mask_r, fwd_data_r);
        bus.init_done        = run_s;
        bus.core_resp_valid  = core_pend_r;
        bus.evict_resp_valid = evict_pend_r;
        bus.core_resp_data   = core_pend_r ? merged_s[resp_word_r*WORD_SIZE +: WORD_SIZE] : '0;
        bus.evict_resp_data  = evict_pend_r ? merged_s : '0;
    end
endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Directed bench for dcache_data_ctrl: a behavioural SRAM, a table of single-cycle vectors and
// hand-written sequences for zero-fill, starvation and reset during operation.
module tb_dcache_data_ctrl;
    localparam int W  = 512;
    localparam int R  = 9;
    localparam int WS = 64;
    localparam int NR = 512;
    localparam int NV = 21;

    typedef struct {
        logic          cv;
        logic          cw;
        logic [R-1:0]  crow;
        logic [2:0]    cword;
        logic [WS-1:0] cwd;
        logic          fv;
        logic [R-1:0]  frow;
        logic [W-1:0]  fd;
        logic          ev;
        logic [R-1:0]  erow;
        logic          xc;
        logic          xf;
        logic          xe;
        logic          xcrv;
        logic [WS-1:0] xcd;
        logic          xerv;
        logic [W-1:0]  xed;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] mem [NR];
    logic [W-1:0] rd_q = '0;
    vec_t         vecs [NV];

    dcache_data_ctrl_if #(.WIDTH(W), .LOG_NUM_ROWS(R), .WORD_SIZE(WS)) bus ();

    dcache_data_ctrl #(.WIDTH(W), .LOG_NUM_ROWS(R), .WORD_SIZE(WS), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural data array: registered read returns the pre-write contents on a same-row collision.
    always @(posedge clk) begin
        rd_q <= mem[bus.sram_read_addr];
        for (int i = 0; i < 8; i++) begin
            if (bus.sram_write_enable[i]) mem[bus.sram_write_addr][i*WS +: WS] <= bus.sram_write_data[i*WS +: WS];
        end
    end
    assign bus.sram_read_data = rd_q;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pat(input logic [WS-1:0] base);
        logic [W-1:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[i*WS +: WS] = base + WS'(i);
        return l;
    endfunction

    function automatic logic [W-1:0] put(input logic [W-1:0] l, input int idx, input logic [WS-1:0] w);
        logic [W-1:0] r;
        r = l;
        r[idx*WS +: WS] = w;
        return r;
    endfunction

    function automatic vec_t rdv(input logic [R-1:0] row, input logic [2:0] word, input logic [WS-1:0] x);
        vec_t v;
        v = '{1'b1, 1'b0, row, word, 64'h0, 1'b0, 9'd0, {W{1'b0}}, 1'b0, 9'd0,
              1'b1, 1'b0, 1'b0, 1'b1, x, 1'b0, {W{1'b0}}};
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic idle();
        bus.core_req_valid  = 1'b0;
        bus.core_req_write  = 1'b0;
        bus.core_req_row    = '0;
        bus.core_req_word   = '0;
        bus.core_req_wdata  = '0;
        bus.fill_valid      = 1'b0;
        bus.fill_row        = '0;
        bus.fill_data       = '0;
        bus.evict_req_valid = 1'b0;
        bus.evict_row       = '0;
    endtask

    task automatic drive(input vec_t v);
        bus.core_req_valid  = v.cv;
        bus.core_req_write  = v.cw;
        bus.core_req_row    = v.crow;
        bus.core_req_word   = v.cword;
        bus.core_req_wdata  = v.cwd;
        bus.fill_valid      = v.fv;
        bus.fill_row        = v.frow;
        bus.fill_data       = v.fd;
        bus.evict_req_valid = v.ev;
        bus.evict_row       = v.erow;
    endtask

    // One request cycle: readys checked before the edge, responses checked in the following cycle.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #1;
        chk("core_ready", idx, W'(bus.core_req_ready), W'(v.xc));
        chk("fill_ready", idx, W'(bus.fill_ready), W'(v.xf));
        chk("evict_ready", idx, W'(bus.evict_req_ready), W'(v.xe));
        @(posedge clk);
        #1;
        idle();
        chk("core_rvalid", idx, W'(bus.core_resp_valid), W'(v.xcrv));
        if (v.xcrv) chk("core_rdata", idx, W'(bus.core_resp_data), W'(v.xcd));
        chk("evict_rvalid", idx, W'(bus.evict_resp_valid), W'(v.xerv));
        if (v.xerv) chk("evict_rdata", idx, bus.evict_resp_data, v.xed);
    endtask

    task automatic chk_rst(input int idx);
        chk("rst_ctrl", idx,
            W'({bus.init_done, bus.core_req_ready, bus.fill_ready, bus.evict_req_ready,
                bus.core_resp_valid, bus.evict_resp_valid, bus.sram_read_addr,
                bus.sram_write_addr, bus.sram_write_enable}),
            W'({6'b000000, 9'd0, 9'd0, 8'hFF}));
        chk("rst_cdata", idx, W'(bus.core_resp_data), {W{1'b0}});
        chk("rst_edata", idx, bus.evict_resp_data, {W{1'b0}});
        chk("rst_wdata", idx, bus.sram_write_data, {W{1'b0}});
    endtask

    // Called just after reset release: row k must be zero-written in cycle k with everything else quiet.
    task automatic init_check(input int n, input int idx);
        int badrows;
        int nonzero;
        badrows = 0;
        nonzero = 0;
        #1;
        for (int k = 0; k < n; k++) begin
            if (bus.sram_write_addr !== R'(k) || bus.sram_write_enable !== 8'hFF ||
                bus.sram_write_data !== {W{1'b0}} || bus.sram_read_addr !== 9'd0 ||
                bus.init_done !== 1'b0 || bus.core_req_ready !== 1'b0 || bus.fill_ready !== 1'b0 ||
                bus.evict_req_ready !== 1'b0 || bus.core_resp_valid !== 1'b0 ||
                bus.evict_resp_valid !== 1'b0) begin
                badrows++;
            end
            @(posedge clk);
            #1;
        end
        chk("init_seq_bad_rows", idx, W'(badrows), {W{1'b0}});
        if (n == NR) begin
            chk("init_done", idx, W'(bus.init_done), W'(1'b1));
            for (int r = 0; r < NR; r++) begin
                if (mem[r] !== {W{1'b0}}) nonzero++;
            end
            chk("init_nonzero_rows", idx, W'(nonzero), {W{1'b0}});
        end
    endtask

    initial begin
        logic [W-1:0] z;
        logic [W-1:0] l3;
        logic [W-1:0] l7;
        logic [W-1:0] l7b;
        logic [W-1:0] l9;
        logic [W-1:0] l20;
        logic [7:0]   crs;
        logic [7:0]   frs;

        z   = {W{1'b0}};
        l3  = put(z, 1, 64'hDEAD_BEEF);
        l7  = pat(64'h1);
        l7b = pat(64'h700);
        l9  = pat(64'h90);
        l20 = pat(64'h200);
        crs = 8'h00;
        frs = 8'h00;

        // fields: cv cw crow cword cwd | fv frow fd | ev erow | xc xf xe | xcrv xcd | xerv xed
        vecs[0]  = rdv(9'd5, 3'd2, 64'h0);
        vecs[1]  = '{1'b1, 1'b1, 9'd3, 3'd1, 64'hDEAD_BEEF, 1'b0, 9'd0, z, 1'b0, 9'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, z};
        vecs[2]  = rdv(9'd3, 3'd1, 64'hDEAD_BEEF);
        vecs[3]  = rdv(9'd3, 3'd0, 64'h0);
        vecs[4]  = '{1'b0, 1'b0, 9'd0, 3'd0, 64'h0, 1'b0, 9'd0, z, 1'b1, 9'd3,
                     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, l3};
        vecs[5]  = '{1'b1, 1'b0, 9'd7, 3'd6, 64'h0, 1'b1, 9'd7, l7, 1'b0, 9'd0,
                     1'b1, 1'b1, 1'b0, 1'b1, 64'h7, 1'b0, z};
        vecs[6]  = rdv(9'd7, 3'd0, 64'h1);
        vecs[7]  = '{1'b0, 1'b0, 9'd0, 3'd0, 64'h0, 1'b1, 9'd9, l9, 1'b0, 9'd0,
                     1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, z};
        vecs[8]  = '{1'b1, 1'b1, 9'd9, 3'd0, 64'h55, 1'b0, 9'd0, z, 1'b1, 9'd9,
                     1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, put(l9, 0, 64'h55)};
        vecs[9]  = rdv(9'd9, 3'd0, 64'h55);
        vecs[10] = rdv(9'd9, 3'd3, 64'h93);
        vecs[11] = '{1'b0, 1'b0, 9'd0, 3'd0, 64'h0, 1'b1, 9'd20, l20, 1'b1, 9'd7,
                     1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, l7};
        vecs[12] = '{1'b0, 1'b0, 9'd0, 3'd0, 64'h0, 1'b1, 9'd7, l7b, 1'b1, 9'd7,
                     1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, l7b};
        vecs[13] = '{1'b1, 1'b0, 9'd5, 3'd0, 64'h0, 1'b0, 9'd0, z, 1'b1, 9'd3,
                     1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, l3};
        vecs[14] = rdv(9'd5, 3'd2, 64'h0);
        vecs[15] = '{1'b1, 1'b1, 9'd20, 3'd7, 64'h1234, 1'b1, 9'd21, l9, 1'b0, 9'd0,
                     1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, z};
        vecs[16] = '{1'b1, 1'b1, 9'd20, 3'd7, 64'h1234, 1'b0, 9'd0, z, 1'b0, 9'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, z};
        vecs[17] = rdv(9'd20, 3'd7, 64'h1234);
        vecs[18] = rdv(9'd20, 3'd6, 64'h206);
        vecs[19] = rdv(9'd21, 3'd1, 64'h91);
        vecs[20] = rdv(9'd7, 3'd5, 64'h705);

        idle();
        repeat (3) @(posedge clk);
        #1;
        chk_rst(0);
        reset = 1'b0;
        init_check(NR, 0);

        for (int i = 0; i < NV; i++) apply(vecs[i], i);

        // Core write held against a continuous fill: blocked four cycles, wins the fifth.
        bus.core_req_valid = 1'b1;
        bus.core_req_write = 1'b1;
        bus.core_req_row   = 9'd30;
        bus.core_req_word  = 3'd2;
        bus.core_req_wdata = 64'hABC;
        bus.fill_valid     = 1'b1;
        bus.fill_row       = 9'd40;
        bus.fill_data      = pat(64'h400);
        for (int c = 0; c < 8; c++) begin
            #1;
            crs[c] = bus.core_req_ready;
            frs[c] = bus.fill_ready;
            @(posedge clk);
            #1;
            if (crs[c]) bus.core_req_valid = 1'b0;
        end
        idle();
        chk("starve_core_ready", 0, W'(crs), W'(8'b0001_0000));
        chk("starve_fill_ready", 0, W'(frs), W'(8'b1110_1111));
        apply(rdv(9'd30, 3'd2, 64'hABC), 100);
        apply(rdv(9'd30, 3'd1, 64'h0), 101);
        apply(rdv(9'd40, 3'd3, 64'h403), 102);

        // Reset part-way through the zero-fill restarts it from row 0.
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        init_check(100, 1);
        chk("init_abort_row", 1, W'(bus.sram_write_addr), W'(9'd100));
        reset = 1'b1;
        #1;
        chk_rst(1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        init_check(NR, 1);

        // Reset right after a read is accepted: its response must never appear.
        bus.core_req_valid = 1'b1;
        bus.core_req_write = 1'b0;
        bus.core_req_row   = 9'd9;
        bus.core_req_word  = 3'd0;
        #1;
        chk("pre_rst_core_ready", 2, W'(bus.core_req_ready), W'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        #1;
        chk_rst(2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        init_check(NR, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_data_ctrl.md
# dcache_data_ctrl

Sequencing and arbitration controller for the L1 D-cache data array (512-bit x 512-row SRAM, 64-bit word write enables, 1-cycle registered read). After reset it zero-fills the whole array, then shares the array's single read port and single write port among three requesters: core word access, line fill (refill) and line eviction (writeback). It also forwards same-cycle write data into read responses.

## Interface
- WIDTH, 512, line width in bits
- LOG_NUM_ROWS, 9, log2 of row count (NUM_ROWS = 2**LOG_NUM_ROWS)
- WORD_SIZE, 64, write-enable granularity; WORDS = WIDTH/WORD_SIZE (8), LOG_WORDS = log2(WORDS) (3)
- STARVE_LIMIT, 4, consecutive blocked core cycles before the core wins the contested port
- clk  in  1  sole clock, all state on posedge
- reset  in  1  asynchronous, active-high
- init_done  out  1  array zero-fill complete, requests may be accepted
- core_req_valid / core_req_ready  in / out  1  core request handshake
- core_req_write  in  1  1 = word write, 0 = word read
- core_req_row  in  LOG_NUM_ROWS  row index
- core_req_word  in  LOG_WORDS  word within row
- core_req_wdata  in  WORD_SIZE  write data
- core_resp_valid  out  1  read data valid (no backpressure)
- core_resp_data  out  WORD_SIZE  read data
- fill_valid / fill_ready  in / out  1  line write handshake
- fill_row  in  LOG_NUM_ROWS; fill_data  in  WIDTH  line to write
- evict_req_valid / evict_req_ready  in / out  1  line read handshake
- evict_row  in  LOG_NUM_ROWS  row to read
- evict_resp_valid  out  1; evict_resp_data  out  WIDTH  line read result
- sram_read_addr  out  LOG_NUM_ROWS; sram_read_data  in  WIDTH
- sram_write_addr  out  LOG_NUM_ROWS; sram_write_data  out  WIDTH; sram_write_enable  out  WORDS

## Operation
- States: INIT, RUN. Reset forces INIT, init counter 0, wait counter 0, pending-read flags cleared.
- INIT: each cycle write row = counter, data 0, enable all ones; counter increments; after row NUM_ROWS-1 go to RUN. All readys 0.
- RUN write port: fill beats core write. Fill: enable all ones, data fill_data. Core write: one-hot enable at core_req_word, wdata placed in that slot, other slots 0.
- RUN read port: evict beats core read.
- Core read and fill, or core write and evict, are non-conflicting and both accepted same cycle.
- Starvation: wait counter increments each RUN cycle with core_req_valid && !core_req_ready, clears on core acceptance, saturates at STARVE_LIMIT. When equal to STARVE_LIMIT, the core wins its port; the conflicting fill_ready/evict_ready is 0 that cycle.
- Readys are combinational from valids/state; transfer on posedge with valid && ready; requesters hold valid and payload until accepted.
- Idle ports: address/data/enable driven 0.
- Forwarding: if a read and a write to the same row are issued in the same cycle, the registered response replaces each word whose enable was set with the written word (SRAM returns old data otherwise).
- Reset mid-operation: in-flight responses are dropped; INIT restarts at row 0.

## Timing
- All outputs 0 while reset asserted and in the first INIT cycle, except sram_write_enable = all ones in INIT.
- INIT: row k written in cycle k after reset release (k = 0..NUM_ROWS-1); init_done = 1 from cycle NUM_ROWS.
- Read issued (accepted) cycle N -> core_resp_valid / evict_resp_valid high exactly in cycle N+1, one cycle only.
- core_resp_data = word core_req_word (captured at N) of the merged line; evict_resp_data = merged line.
- Write accepted in cycle N is visible to a read issued in N (via forwarding) and in N+1 and later (from array).
- Back-to-back reads each cycle sustain one response per cycle.

## Test plan
- Reset release -> rows 0..511 written with 0, enable 0xFF, over 512 cycles; init_done rises at cycle 512; core read row 5 word 2 -> resp 0 next cycle.
- Core write row 3 word 1 = 0xDEAD_BEEF, next cycle core read row 3 word 1 -> resp 0xDEAD_BEEF one cycle later; other words of row 3 still 0.
- Same cycle fill row 7 (word i = i+1) and core read row 7 word 6 -> resp 7 (forwarded), not 0.
- fill_valid held high for 8 cycles while core write pending -> core stalls 4 cycles, accepted in 5th cycle with fill_ready 0 that cycle, fill resumes after.
- Same cycle evict row 9 and core write row 9 word 0 = 0x55 -> both accepted; evict_resp_data word 0 = 0x55, others old values.
- Assert reset at INIT count 100, and separately one cycle after a read is accepted -> all outputs 0 immediately, no response emitted, INIT restarts at row 0.
